// File: rtl/regfile_dump_if.sv
// Control, regfile read port and output stream of the register dump sequencer.
// master = the sequencer; slave = the requester / regfile / stream consumer side.
interface regfile_dump_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] first_reg;
    logic [ADDR_W-1:0] last_reg;
    logic [ADDR_W-1:0] ctrl_readReg;
    logic [DATA_W-1:0] data_readReg;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_index;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              busy;
    logic              done;

    modport master (
        input  start, abort, first_reg, last_reg, data_readReg, out_ready,
        output ctrl_readReg, out_valid, out_index, out_data, out_last, busy, done
    );

    modport slave (
        output start, abort, first_reg, last_reg, data_readReg, out_ready,
        input  ctrl_readReg, out_valid, out_index, out_data, out_last, busy, done
    );
endinterface

// File: rtl/regfile_dump.sv
// Walks a wrap-around register index range through one regfile read port and streams {index,data}.
// First word 3 edges after start, then 3 cycles per word; words hold stable while out_ready is low.
module regfile_dump #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic            clock,
    input  logic            ctrl_reset,
    regfile_dump_if.master  bus
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETTLE  = 3'd1,
        CAPTURE = 3'd2,
        SEND    = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cur_q, cur_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              vld_q, vld_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] dat_q, dat_d;
    logic              olast_q, olast_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            state_q   <= IDLE;
            cur_q     <= '0;
            last_q    <= '0;
            rd_addr_q <= '0;
            vld_q     <= 1'b0;
            idx_q     <= '0;
            dat_q     <= '0;
            olast_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            last_q    <= last_d;
            rd_addr_q <= rd_addr_d;
            vld_q     <= vld_d;
            idx_q     <= idx_d;
            dat_q     <= dat_d;
            olast_q   <= olast_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        last_d    = last_q;
        rd_addr_d = rd_addr_q;
        vld_d     = vld_q;
        idx_d     = idx_q;
        dat_d     = dat_q;
        olast_d   = olast_q;

        // Abort wins over everything, including a handshake in the same cycle.
        if (bus.abort && state_q != IDLE) begin
            state_d = IDLE;
            vld_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        cur_d     = bus.first_reg;
                        last_d    = bus.last_reg;
                        rd_addr_d = bus.first_reg;
                        state_d   = SETTLE;
                    end
                end
                SETTLE: state_d = CAPTURE;
                CAPTURE: begin
                    dat_d   = bus.data_readReg;
                    idx_d   = cur_q;
                    olast_d = (cur_q == last_q);
                    vld_d   = 1'b1;
                    state_d = SEND;
                end
                SEND: begin
                    if (bus.out_ready) begin
                        vld_d = 1'b0;
                        if (olast_q) begin
                            state_d = DONE;
                        end else begin
                            cur_d     = cur_q + ADDR_W'(1);
                            rd_addr_d = cur_q + ADDR_W'(1);
                            state_d   = SETTLE;
                        end
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        // Status flags are registered copies of the next state so they line up with it.
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    assign bus.ctrl_readReg = rd_addr_q;
    assign bus.out_valid    = vld_q;
    assign bus.out_index    = idx_q;
    assign bus.out_data     = dat_q;
    assign bus.out_last     = olast_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
endmodule

// File: tb/tb_regfile_dump.sv
// Scoreboarded bench: stimulus pushes expected {last,index,data}; a negedge monitor pops on each handshake.
module tb_regfile_dump;
    logic clock;
    logic ctrl_reset;
    logic [31:0] regs [32];

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0;
    logic [37:0] exp_q [$];

    regfile_dump_if #(.ADDR_W(5), .DATA_W(32)) bus ();

    regfile_dump #(.ADDR_W(5), .DATA_W(32)) dut (
        .clock      (clock),
        .ctrl_reset (ctrl_reset),
        .bus        (bus.master)
    );

    assign bus.data_readReg = regs[bus.ctrl_readReg];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [4:0] idx, input logic [31:0] dat, input logic lst);
        exp_q.push_back({lst, idx, dat});
    endtask

    // Monitor: a word with valid&&ready at a negedge is taken at the following posedge.
    always @(negedge clock) begin
        if (ctrl_reset && bus.done) done_cnt++;
        if (ctrl_reset && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL word: unexpected {last,idx,data}=%h", {bus.out_last, bus.out_index, bus.out_data});
            end else begin
                check("word", 64'({bus.out_last, bus.out_index, bus.out_data}), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic do_start(input logic [4:0] f, input logic [4:0] l);
        bus.start = 1'b1;
        bus.first_reg = f;
        bus.last_reg = l;
        @(posedge clock);
        #1 bus.start = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        bit seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (bus.out_valid) begin seen = 1; break; end
        end
        check(name, 64'(seen), 64'd1);
    endtask

    task automatic wait_done(input string name);
        bit seen = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            if (bus.done) begin seen = 1; break; end
        end
        check({name, "_done"}, 64'(seen), 64'd1);
        check({name, "_busy_at_done"}, 64'(bus.busy), 64'd1);
        @(negedge clock);
        check({name, "_done_one_cycle"}, 64'(bus.done), 64'd0);
        check({name, "_busy_after"}, 64'(bus.busy), 64'd0);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_rdaddr"}, 64'(bus.ctrl_readReg), 64'd0);
        check({name, "_valid"},  64'(bus.out_valid), 64'd0);
        check({name, "_index"},  64'(bus.out_index), 64'd0);
        check({name, "_data"},   64'(bus.out_data), 64'd0);
        check({name, "_last"},   64'(bus.out_last), 64'd0);
        check({name, "_busy"},   64'(bus.busy), 64'd0);
        check({name, "_done"},   64'(bus.done), 64'd0);
    endtask

    initial begin
        int d0;
        ctrl_reset = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.first_reg = '0;
        bus.last_reg = '0;
        bus.out_ready = 1'b1;
        regs[0] = 32'h0;
        for (int i = 1; i < 32; i++) regs[i] = 32'h0000DEAD + 32'(i);

        #12 check_all_zero("reset");
        #10 ctrl_reset = 1'b1;
        @(negedge clock);

        // Full dump 0..31 with ready held high.
        for (int i = 0; i < 32; i++) push(5'(i), (i == 0) ? 32'h0 : 32'h0000DEAD + 32'(i), i == 31);
        do_start(5'd0, 5'd31);
        wait_done("full");
        check("full_drained", 64'(exp_q.size()), 64'd0);

        // Single word plus start-to-valid latency.
        regs[5] = 32'hCAFEF00D;
        push(5'd5, 32'hCAFEF00D, 1'b1);
        @(negedge clock);
        do_start(5'd5, 5'd5);
        @(negedge clock) check("lat_e0", 64'(bus.out_valid), 64'd0);
        @(negedge clock) check("lat_e1", 64'(bus.out_valid), 64'd0);
        @(negedge clock) check("lat_e2", 64'(bus.out_valid), 64'd1);
        wait_done("single");

        // Wrap-around 30..1.
        push(5'd30, 32'h0000DECB, 1'b0);
        push(5'd31, 32'h0000DECC, 1'b0);
        push(5'd0,  32'h00000000, 1'b0);
        push(5'd1,  32'h0000DEAE, 1'b1);
        do_start(5'd30, 5'd1);
        wait_done("wrap");
        check("wrap_drained", 64'(exp_q.size()), 64'd0);

        // Backpressure on the second word of 10..13.
        push(5'd10, 32'h0000DEB7, 1'b0);
        push(5'd11, 32'h0000DEB8, 1'b0);
        push(5'd12, 32'h0000DEB9, 1'b0);
        push(5'd13, 32'h0000DEBA, 1'b1);
        do_start(5'd10, 5'd13);
        wait_valid("bp_first_valid");
        @(posedge clock);
        #1 bus.out_ready = 1'b0;
        wait_valid("bp_second_valid");
        for (int i = 0; i < 7; i++) begin
            if (i != 0) @(negedge clock);
            check("bp_valid", 64'(bus.out_valid), 64'd1);
            check("bp_index", 64'(bus.out_index), 64'd11);
            check("bp_data",  64'(bus.out_data), 64'h0000DEB8);
        end
        @(posedge clock);
        #1 bus.out_ready = 1'b1;
        wait_done("bp");
        check("bp_drained", 64'(exp_q.size()), 64'd0);

        // Start while busy is ignored.
        push(5'd20, 32'h0000DEC1, 1'b0);
        push(5'd21, 32'h0000DEC2, 1'b0);
        push(5'd22, 32'h0000DEC3, 1'b1);
        do_start(5'd20, 5'd22);
        @(posedge clock);
        #1 do_start(5'd3, 5'd4);
        wait_done("busy_start");
        check("busy_start_drained", 64'(exp_q.size()), 64'd0);

        // Abort during SEND with the word still pending.
        bus.out_ready = 1'b0;
        do_start(5'd7, 5'd9);
        wait_valid("abort_valid");
        d0 = done_cnt;
        bus.abort = 1'b1;
        @(posedge clock);
        #1 bus.abort = 1'b0;
        @(negedge clock);
        check("abort_valid_low", 64'(bus.out_valid), 64'd0);
        check("abort_busy_low",  64'(bus.busy), 64'd0);
        repeat (4) @(negedge clock);
        check("abort_no_done", 64'(done_cnt), 64'(d0));

        // Asynchronous reset mid-SEND, then a normal dump.
        do_start(5'd15, 5'd16);
        wait_valid("rst_valid");
        #3 ctrl_reset = 1'b0;
        #1 check_all_zero("async_rst");
        #13 ctrl_reset = 1'b1;
        @(negedge clock);
        bus.out_ready = 1'b1;
        push(5'd2, 32'h0000DEAF, 1'b0);
        push(5'd3, 32'h0000DEB0, 1'b1);
        do_start(5'd2, 5'd3);
        wait_done("post_rst");
        check("final_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
